// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode/control unit and the PC sequencer.
// master: control unit (drives stall/inc/jump/call/ret, observes pc and stack status).
// slave : pc_sequencer (consumes controls, drives pc, sp_level and stack flags).
interface pc_sequencer_if #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic          stall;
  logic          inc_en;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          call_en;
  logic [AW-1:0] call_addr;
  logic          ret_en;
  logic [AW-1:0] pc;
  logic [SPW-1:0] sp_level;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  modport master (
    output stall, inc_en, jump_en, jump_addr, call_en, call_addr, ret_en,
    input  pc, sp_level, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  stall, inc_en, jump_en, jump_addr, call_en, call_addr, ret_en,
    output pc, sp_level, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: increment, qualified jump, call/return via LIFO.
// Latency: every control takes effect on pc one clock later; all outputs come from registers.
// Backpressure: stall freezes pc and stack (jump qualifier still samples). Optional macro
// PC_STACK_GUARD_EN rejects call-on-full / ret-on-empty and raises a sticky stack_err.
// Ports: clk, rst (sync, active-high), bus (pc_sequencer_if.slave: controls in, pc/stack status out).
module pc_sequencer #(
  parameter int            AW         = 8,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int            JUMP_QUAL  = 1
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [AW-1:0]  pc_r, pc_nxt, pc_inc, top_val;
  logic [SPW-1:0] sp_r, sp_nxt;
  logic [AW-1:0]  stack_r [DEPTH];
  logic           jump_q;
  logic           push;        // write at sp, stack not full
  logic           push_shift;  // full: drop oldest entry, write newest at the top slot
  logic           full, empty;
`ifdef PC_STACK_GUARD_EN
  logic           err_set;
  logic           err_r;
`endif

  assign pc_inc = pc_r + AW'(1);
  assign full   = (sp_r == SPW'(DEPTH));
  assign empty  = (sp_r == '0);

  // Entry just below sp; chosen by comparison so no index-width games are needed.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_r == SPW'(i + 1)) top_val = stack_r[i];
    end
  end

  always_comb begin
    pc_nxt     = pc_r;
    sp_nxt     = sp_r;
    push       = 1'b0;
    push_shift = 1'b0;
`ifdef PC_STACK_GUARD_EN
    err_set    = 1'b0;
`endif
    if (!bus.stall) begin
      if (bus.ret_en) begin
        if (!empty) begin
          pc_nxt = top_val;
          sp_nxt = sp_r - SPW'(1);
        end else begin
`ifdef PC_STACK_GUARD_EN
          err_set = 1'b1;
`else
          pc_nxt = RESET_ADDR;
`endif
        end
      end else if (bus.call_en) begin
        if (!full) begin
          push   = 1'b1;
          sp_nxt = sp_r + SPW'(1);
          pc_nxt = bus.call_addr;
        end else begin
`ifdef PC_STACK_GUARD_EN
          err_set = 1'b1;
`else
          push_shift = 1'b1;
          pc_nxt     = bus.call_addr;
`endif
        end
      end else if (bus.jump_en) begin
        // First cycle of a qualified jump holds pc and still blocks inc_en.
        if (JUMP_QUAL == 0 || jump_q) pc_nxt = bus.jump_addr;
      end else if (bus.inc_en) begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r   <= RESET_ADDR;
      sp_r   <= '0;
      jump_q <= 1'b0;
    end else begin
      jump_q <= bus.jump_en;  // samples even while stalled
      pc_r   <= pc_nxt;
      sp_r   <= sp_nxt;
    end
  end

  // Stack storage needs no reset: sp_level alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && sp_r == SPW'(i)) stack_r[i] <= pc_inc;
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (push_shift) stack_r[i] <= stack_r[i + 1];
      end
      if (push_shift) stack_r[DEPTH - 1] <= pc_inc;
    end
  end

`ifdef PC_STACK_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst)          err_r <= 1'b0;
    else if (err_set) err_r <= 1'b1;
  end
  assign bus.stack_err = err_r;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.pc          = pc_r;
  assign bus.sp_level    = sp_r;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (AW=8, DEPTH=4, RESET_ADDR=0, JUMP_QUAL=1).
// Expected values are hand-computed; guard-dependent ones switch on PC_STACK_GUARD_EN.
module tb_pc_sequencer;
`ifdef PC_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.AW(8), .DEPTH(4)) bus ();

  pc_sequencer #(.AW(8), .DEPTH(4), .RESET_ADDR(8'h00), .JUMP_QUAL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.inc_en = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = '0;
    bus.call_en = 1'b0; bus.call_addr = '0; bus.ret_en = 1'b0;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] epc, input logic [2:0] esp, input logic eerr);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(epc));
    chk({tag, ".sp"}, 32'(bus.sp_level), 32'(esp));
    chk({tag, ".err"}, 32'(bus.stack_err), 32'(eerr));
  endtask

  logic [7:0] call_tgt [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] ret_off  [5] = '{8'h45, 8'h34, 8'h23, 8'h12, 8'h00};
  logic [7:0] ret_on   [5] = '{8'h34, 8'h23, 8'h12, 8'h08, 8'h08};
  logic [2:0] ret_sp   [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
  logic [7:0] base_pc;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_st("reset", 8'h00, 3'd0, 1'b0);
    chk("reset.empty", 32'(bus.stack_empty), 32'd1);
    chk("reset.full", 32'(bus.stack_full), 32'd0);

    // Free-running increment across the 8-bit wrap.
    bus.inc_en = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      tick();
      chk("inc", 32'(bus.pc), 32'(k % 256));
    end
    chk_st("inc.end", 8'h04, 3'd0, 1'b0);

    // Reposition to 0x10 by reset + 16 increments.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    chk("pc10", 32'(bus.pc), 32'h10);

    // Qualified jump: first cycle holds (blocks inc), second loads.
    bus.jump_en = 1'b1; bus.jump_addr = 8'h40;
    tick(); chk("jq.hold", 32'(bus.pc), 32'h10);
    tick(); chk("jq.load", 32'(bus.pc), 32'h40);
    bus.jump_en = 1'b0; bus.inc_en = 1'b0;
    tick(); chk("jq.idle", 32'(bus.pc), 32'h40);
    // One-cycle glitch: holds, never loads.
    bus.jump_en = 1'b1; bus.jump_addr = 8'h99; bus.inc_en = 1'b1;
    tick(); chk("glitch.hold", 32'(bus.pc), 32'h40);
    bus.jump_en = 1'b0;
    tick(); chk("glitch.inc", 32'(bus.pc), 32'h41);
    bus.inc_en = 1'b0;

    // Jump to 0x05.
    bus.jump_en = 1'b1; bus.jump_addr = 8'h05;
    tick(); tick();
    bus.jump_en = 1'b0;
    chk("pc05", 32'(bus.pc), 32'h05);

    // Nested call / return.
    bus.call_en = 1'b1; bus.call_addr = 8'h80; tick(); chk_st("call1", 8'h80, 3'd1, 1'b0);
    bus.call_addr = 8'hA0; tick(); chk_st("call2", 8'hA0, 3'd2, 1'b0);
    bus.call_en = 1'b0; bus.ret_en = 1'b1;
    tick(); chk_st("ret1", 8'h81, 3'd1, 1'b0);
    tick(); chk_st("ret2", 8'h06, 3'd0, 1'b0);
    chk("ret2.empty", 32'(bus.stack_empty), 32'd1);
    bus.ret_en = 1'b0;

    // call and ret together: ret wins.
    bus.call_en = 1'b1; bus.call_addr = 8'h30; tick(); chk_st("callx", 8'h30, 3'd1, 1'b0);
    bus.ret_en = 1'b1; bus.call_addr = 8'h55; tick(); chk_st("callret", 8'h07, 3'd0, 1'b0);
    bus.ret_en = 1'b0;

    // Five nested calls into a 4-deep stack.
    for (int k = 0; k < 5; k++) begin
      bus.call_addr = call_tgt[k];
      tick();
      if (k < 4) chk_st("ncall", call_tgt[k], 3'(k + 1), 1'b0);
      else       chk_st("ncall5", GUARD ? 8'h44 : 8'h55, 3'd4, GUARD);
    end
    chk("ncall.full", 32'(bus.stack_full), 32'd1);
    bus.call_en = 1'b0; bus.ret_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_st("nret", GUARD ? ret_on[k] : ret_off[k], ret_sp[k], GUARD);
    end
    bus.ret_en = 1'b0;
    base_pc = GUARD ? 8'h08 : 8'h00;

    // Stall freezes pc and stack.
    bus.call_en = 1'b1; bus.call_addr = 8'h70; tick(); chk_st("scall", 8'h70, 3'd1, GUARD);
    bus.call_en = 1'b0; bus.stall = 1'b1;
    bus.inc_en = 1'b1; tick(); chk_st("stall.inc", 8'h70, 3'd1, GUARD);
    bus.inc_en = 1'b0; bus.call_en = 1'b1; bus.call_addr = 8'h10;
    tick(); chk_st("stall.call", 8'h70, 3'd1, GUARD);
    bus.call_en = 1'b0; bus.ret_en = 1'b1;
    tick(); chk_st("stall.ret", 8'h70, 3'd1, GUARD);
    bus.ret_en = 1'b0; bus.stall = 1'b0; bus.inc_en = 1'b1;
    tick(); chk_st("unstall.inc", 8'h71, 3'd1, GUARD);
    bus.inc_en = 1'b0; bus.ret_en = 1'b1;
    tick(); chk_st("unstall.ret", base_pc + 8'h01, 3'd0, GUARD);
    bus.ret_en = 1'b0;
    // Qualifier samples during stall, so the next cycle's jump loads at once.
    bus.stall = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 8'h66;
    tick(); chk("stall.jq", 32'(bus.pc), 32'(base_pc + 8'h01));
    bus.stall = 1'b0;
    tick(); chk("stall.jload", 32'(bus.pc), 32'h66);
    bus.jump_en = 1'b0;
    tick();

    // Reset mid-qualification with two stack entries.
    bus.call_en = 1'b1; bus.call_addr = 8'h20; tick();
    bus.call_addr = 8'h30; tick();
    bus.call_en = 1'b0;
    chk("pre_rst.sp", 32'(bus.sp_level), 32'd2);
    bus.jump_en = 1'b1; bus.jump_addr = 8'h44;
    tick(); chk("pre_rst.hold", 32'(bus.pc), 32'h30);
    rst = 1'b1;
    tick(); chk_st("rst", 8'h00, 3'd0, 1'b0);
    chk("rst.empty", 32'(bus.stack_empty), 32'd1);
    rst = 1'b0;
    tick(); chk("post_rst.hold", 32'(bus.pc), 32'h00);
    tick(); chk("post_rst.load", 32'(bus.pc), 32'h44);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
